// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared states, defaults and sizing helpers for the FIFO byte reader
package fifo_rd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CAPT,
    SYNC,
    SEND
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         WORD_WIDTH_DEF = 48;
  localparam int         NBYTES         = WORD_WIDTH_DEF / 8;
  localparam int         IDX_W          = $clog2(NBYTES);

  // Keeps the byte index at least one bit wide for single-byte words.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/fifo_byte_reader.sv
// rtl/fifo_byte_reader.sv - pops 48-bit FIFO words and streams them out MSB byte first
// Every output is decoded from the state and shift registers only.
module fifo_byte_reader
  import fifo_rd_pkg::*;
#(
  parameter int         WORD_WIDTH = WORD_WIDTH_DEF,
  parameter bit         SYNC_EN    = 1'b1,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [WORD_WIDTH-1:0] fifo_data,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_count
);

  localparam int             NB       = WORD_WIDTH / 8;
  localparam int             IW       = idx_width(NB);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NB - 1);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q,   idx_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (!fifo_empty) state_d = POP;
      POP:  state_d = CAPT;
      CAPT: begin
        // Read data is registered in the FIFO, so it lands one cycle after the pop.
        shift_d = fifo_data;
        idx_d   = '0;
        if (SYNC_EN) state_d = SYNC;
        else         state_d = SEND;
      end
      SYNC: if (tx_ready) state_d = SEND;
      SEND: begin
        if (tx_ready) begin
          shift_d = shift_q << 8;
          idx_d   = idx_q + IW'(1);
          if (idx_q == LAST_IDX) begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_rd_en = (state_q == POP);
  assign tx_valid   = (state_q == SYNC) || (state_q == SEND);
  assign tx_data    = (state_q == SYNC) ? SYNC_BYTE :
                      (state_q == SEND) ? shift_q[WORD_WIDTH-1 -: 8] : 8'h00;
  assign busy       = (state_q != IDLE);
  assign word_count = cnt_q;

endmodule

// File: tb/tb_fifo_byte_reader.sv
// tb/tb_fifo_byte_reader.sv - randomized bench with a byte-stream reference model
// Instance 0 sends sync bytes with a 4-bit counter; instance 1 has no sync byte.
module tb_fifo_byte_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tx_ready;
  logic        emp_a, emp_b, rd_a, rd_b, v_a, v_b, busy_a, busy_b;
  logic [47:0] fd_a = '0, fd_b = '0;
  logic [7:0]  d_a, d_b;
  logic [3:0]  wc_a;
  logic [15:0] wc_b;

  fifo_byte_reader #(.WORD_WIDTH(48), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5), .CNT_WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_empty(emp_a), .fifo_rd_en(rd_a), .fifo_data(fd_a),
    .tx_data(d_a), .tx_valid(v_a), .tx_ready(tx_ready), .busy(busy_a), .word_count(wc_a));

  fifo_byte_reader #(.WORD_WIDTH(48), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_empty(emp_b), .fifo_rd_en(rd_b), .fifo_data(fd_b),
    .tx_data(d_b), .tx_valid(v_b), .tx_ready(tx_ready), .busy(busy_b), .word_count(wc_b));

  int n_pass = 0, n_total = 0, cyc = 0;

  // FIFO models: words written by the stimulus, popped with registered read data.
  logic [47:0] mem [2][0:63];
  int wp[2] = '{0, 0};
  int rp[2] = '{0, 0};
  assign emp_a = (wp[0] == rp[0]);
  assign emp_b = (wp[1] == rp[1]);

  // Reference model: expected byte stream per instance plus frame progress.
  logic [7:0] eb [2][0:255];
  int ewp[2] = '{0, 0};
  int erp[2] = '{0, 0};
  int pos[2] = '{0, 0};
  int cmpl[2] = '{0, 0};
  int done[2] = '{0, 0};
  int nrd[2] = '{0, 0};
  int nx[2] = '{0, 0};
  logic stall[2] = '{1'b0, 1'b0};
  logic [7:0] sdata[2] = '{8'h00, 8'h00};
  int xedge [2][0:511];
  logic [7:0] xbyte [2][0:511];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rd_a && wp[0] != rp[0]) begin fd_a <= mem[0][rp[0]]; rp[0] <= rp[0] + 1; end
    if (rd_b && wp[1] != rp[1]) begin fd_b <= mem[1][rp[1]]; rp[1] <= rp[1] + 1; end
  end

  function automatic int flen(input int i);
    return (i == 0) ? 7 : 6;
  endfunction

  function automatic logic [7:0] fbyte(input logic [47:0] w, input bit sync, input int k);
    int j;
    if (sync && k == 0) return 8'hA5;
    j = sync ? k - 1 : k;
    return 8'(w >> (40 - 8 * j));
  endfunction

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input int i, input logic [47:0] w);
    mem[i][wp[i]] = w;
    for (int k = 0; k < flen(i); k++) begin
      eb[i][ewp[i]] = fbyte(w, i == 0, k);
      ewp[i]++;
    end
    wp[i]++;
  endtask

  task automatic step(input int i, input logic v, input logic [7:0] d, input logic rd,
                      input logic emp, input logic bsy, input logic [15:0] wc,
                      input logic [15:0] mask);
    if (!rst_n) begin
      // A popped word that has not completed is dropped by reset.
      if (rp[i] > done[i]) begin erp[i] += flen(i) - pos[i]; done[i]++; end
      pos[i] = 0; cmpl[i] = 0; stall[i] = 1'b0;
      check("reset_outputs", 48'({rd, v, bsy, d, wc}), 48'(0));
    end else begin
      check("word_count", 48'(wc), 48'(16'(cmpl[i]) & mask));
      if (rd) begin nrd[i]++; check("rd_en_nonempty", 48'(emp), 48'(0)); end
      if (v) check("valid_busy", 48'(bsy), 48'(1));
      if (stall[i]) begin
        check("stall_valid", 48'(v), 48'(1));
        check("stall_data", 48'(d), 48'(sdata[i]));
      end
      if (v && tx_ready) begin
        if (erp[i] == ewp[i]) begin
          n_total++;
          $display("FAIL unexpected_byte: got %0h expected no transfer", d);
        end else begin
          check("byte", 48'(d), 48'(eb[i][erp[i]]));
          erp[i]++;
        end
        xedge[i][nx[i]] = cyc + 1;
        xbyte[i][nx[i]] = d;
        nx[i]++;
        pos[i]++;
        if (pos[i] == flen(i)) begin pos[i] = 0; cmpl[i]++; done[i]++; end
      end
      stall[i] = v && !tx_ready;
      sdata[i] = d;
    end
  endtask

  always @(negedge clk) begin
    step(0, v_a, d_a, rd_a, emp_a, busy_a, {12'h000, wc_a}, 16'h000F);
    step(1, v_b, d_b, rd_b, emp_b, busy_b, wc_b, 16'hFFFF);
  end

  task automatic wait_xfer(input int i, input int target, input int budget, input bit rnd);
    int n;
    n = 0;
    while (nx[i] < target && n < budget) begin
      @(posedge clk); #2;
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("xfer_reached", 48'(nx[i] >= target), 48'(1));
  endtask

  logic [7:0]  sw_exp [0:6] = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
  logic [47:0] w;
  int base, r0, p, bad;

  initial begin
    rst_n = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_rd_en", 48'(rd_a), 48'(0));
    check("rst_tx_valid", 48'(v_a), 48'(0));
    check("rst_tx_data", 48'(d_a), 48'(0));
    check("rst_busy", 48'(busy_a), 48'(0));
    check("rst_word_count", 48'(wc_a), 48'(0));
    rst_n = 1'b1;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rd_a || v_a || busy_a || rd_b || v_b || busy_b) bad++;
    end
    check("idle_quiet", 48'(bad), 48'(0));
    @(posedge clk); #2;

    // Single word, tx_ready held high.
    base = nx[0]; r0 = nrd[0]; p = cyc;
    push(0, 48'h0123_4567_89AB);
    wait_xfer(0, base + 7, 50, 1'b0);
    check("sw_busy_low", 48'(busy_a), 48'(0));
    check("sw_word_count", 48'(wc_a), 48'(1));
    check("sw_rd_cycles", 48'(nrd[0] - r0), 48'(1));
    for (int k = 0; k < 7; k++) begin
      check("sw_byte", 48'(xbyte[0][base + k]), 48'(sw_exp[k]));
      check("sw_edge", 48'(xedge[0][base + k]), 48'(p + 4 + k));
    end

    // Same word under random backpressure.
    base = nx[0];
    push(0, 48'h0123_4567_89AB);
    wait_xfer(0, base + 7, 400, 1'b1);
    tx_ready = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    check("bp_xfers", 48'(nx[0] - base), 48'(7));
    for (int k = 0; k < 7; k++) check("bp_byte", 48'(xbyte[0][base + k]), 48'(sw_exp[k]));
    check("bp_word_count", 48'(wc_a), 48'(2));

    // Back-to-back words without sync.
    base = nx[1];
    push(1, 48'hAAAA_AAAA_AAAA);
    push(1, 48'h5555_5555_5555);
    wait_xfer(1, base + 12, 100, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("b2b_xfers", 48'(nx[1] - base), 48'(12));
    check("b2b_gap", 48'(xedge[1][base + 6] - xedge[1][base + 5]), 48'(4));
    check("b2b_first", 48'(xbyte[1][base]), 48'(8'hAA));
    check("b2b_second", 48'(xbyte[1][base + 6]), 48'(8'h55));
    check("b2b_word_count", 48'(wc_b), 48'(2));
    check("b2b_empty", 48'(emp_b), 48'(1));

    // Reset in the middle of a word.
    base = nx[0];
    w = {$urandom, $urandom};
    push(0, 48'h0123_4567_89AB);
    push(0, w);
    wait_xfer(0, base + 3, 50, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 48'(v_a), 48'(0));
    check("rst_async_count", 48'(wc_a), 48'(0));
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    base = nx[0];
    wait_xfer(0, base + 7, 60, 1'b0);
    check("post_rst_sync", 48'(xbyte[0][base]), 48'(8'hA5));
    check("post_rst_count", 48'(wc_a), 48'(1));

    // Counter wrap with a 4-bit word_count.
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    base = nx[0];
    for (int k = 0; k < 17; k++) begin
      w = {$urandom, $urandom};
      push(0, w);
    end
    wait_xfer(0, base + 17 * 7, 3000, 1'b1);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("wrap_word_count", 48'(wc_a), 48'(1));
    check("drain_a", 48'(ewp[0] - erp[0]), 48'(0));
    check("drain_b", 48'(ewp[1] - erp[1]), 48'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_byte_reader.md
# fifo_byte_reader

Drain side of the 48-bit sample FIFO. Pops one word at a time through the FIFO's read port, honouring its one-cycle registered read latency. Emits each word as an optional sync byte followed by the word's bytes, MSB first, on an 8-bit valid/ready stream toward the UART/USB byte transmitter. It also keeps a running count of words fully sent.

## Interface
Parameters:
- `WORD_WIDTH`, 48: FIFO word width. Must be a multiple of 8. NBYTES = WORD_WIDTH/8.
- `SYNC_EN`, 1: when 1, each word is preceded by `SYNC_BYTE`.
- `SYNC_BYTE`, 8'hA5: frame marker value.
- `CNT_WIDTH`, 16: width of `word_count`.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_rd_en`, out, 1: FIFO pop request. Never asserted while `fifo_empty` = 1.
- `fifo_data`, in, `WORD_WIDTH`: FIFO registered read data. Valid the cycle after the pop.
- `tx_data`, out, 8: byte to transmitter.
- `tx_valid`, out, 1: `tx_data` valid.
- `tx_ready`, in, 1: transmitter accepts the byte. A transfer occurs on `tx_valid && tx_ready` at a rising edge.
- `busy`, out, 1: high in every state except IDLE.
- `word_count`, out, `CNT_WIDTH`: number of words whose last byte was accepted. Wraps to 0.

## Operation
FSM states: IDLE, POP, CAPT, SYNC, SEND.

- IDLE: `fifo_rd_en` = 0, `tx_valid` = 0. If `fifo_empty` = 0, go to POP.
- POP: `fifo_rd_en` = 1 for exactly one cycle. Go to CAPT.
- CAPT: latch `fifo_data` into the shift register. Set the byte index to 0. Go to SYNC if `SYNC_EN`, else SEND.
- SYNC: `tx_valid` = 1, `tx_data` = `SYNC_BYTE`. Stay until accepted, then go to SEND.
- SEND: `tx_valid` = 1, `tx_data` = shift register bits [WORD_WIDTH-1 -: 8].
  - On each accept, shift left 8 and increment the byte index.
  - On accept of byte NBYTES-1: increment `word_count` and go to IDLE.

Outputs and rules:
- `fifo_rd_en`, `tx_valid`, `tx_data` and `busy` are registered or decoded from the state register only. They have no combinational path from `tx_ready` or `fifo_empty`.
- `tx_data` and `tx_valid` must stay stable while `tx_valid` = 1 and `tx_ready` = 0. `tx_valid` never deasserts before acceptance.
- `fifo_empty` is ignored outside IDLE. `fifo_data` is sampled only in CAPT.

## Timing
- Reset values (asynchronous on `rst_n` = 0): state IDLE, `fifo_rd_en` = 0, `tx_valid` = 0, `tx_data` = 8'h00, `busy` = 0, `word_count` = 0, shift register 0.
- Latency, counted from IDLE sampling `fifo_empty` = 0 at edge E0:
  - `fifo_rd_en` is high in cycle E0..E1.
  - Capture happens at E2.
  - The first `tx_valid` is high in cycle E2..E3.
- Throughput with `tx_ready` held at 1: NBYTES + SYNC_EN + 3 cycles per word. This is 10 cycles for 48 bits with sync.
- Back-to-back words: after the last byte is accepted, exactly one IDLE cycle precedes the next POP.
- Reset mid-word: the in-flight word is lost and `tx_valid` drops immediately. The popped word is not re-read.
- `word_count` at all-ones plus one completion wraps to 0, with no flag.

## Structure
- Package `fifo_rd_pkg` holds:
  - the state enum (IDLE, POP, CAPT, SYNC, SEND);
  - default `SYNC_BYTE`;
  - localparam NBYTES, and the byte-index width $clog2(NBYTES).
- The block is a single module with no sub-module. The shift register and FSM are small enough to live together.

## Test plan
- Single word: preload the FIFO with 48'h0123_4567_89AB, `SYNC_EN` = 1, `tx_ready` = 1.
  - Required bytes: A5, 01, 23, 45, 67, 89, AB on consecutive cycles.
  - `fifo_rd_en` is high for exactly 1 cycle.
  - `word_count` = 1, and `busy` falls after AB.
- Backpressure: same word, `tx_ready` toggling 1-0-0-1 randomly.
  - Byte order is unchanged.
  - `tx_data` is stable during each stall.
  - Only 7 transfers occur in total.
- Back-to-back: preload 48'hAAAA_AAAA_AAAA and 48'h5555_5555_5555, `SYNC_EN` = 0, `tx_ready` = 1.
  - 12 bytes are emitted, with exactly 3 non-valid cycles between the two words.
  - `word_count` = 2, and `fifo_empty` = 1 at the end.
- Empty FIFO for 100 cycles: `fifo_rd_en`, `tx_valid` and `busy` all stay 0.
- Reset mid-word: assert `rst_n` = 0 during SEND byte 3.
  - `tx_valid` goes to 0 asynchronously and `word_count` = 0.
  - After release, the next FIFO word is sent starting with A5.
- Counter wrap: with `CNT_WIDTH` = 4, send 17 words. Required `word_count` = 1.
